mult_arbiter: RTL
=================

// Module: mult_arbiter
//
// PURPOSE
// - Shares one pipelined signed 17x16 fractional multiplier between NREQ requesters.
// - Requesters are the filter loop, the voice envelope/volume scaler and the master volume.
// - Grants at most one operand pair per cycle and returns each result 2 cycles after its grant.
// - Result is returned on a shared bus with a one-hot per-requester valid strobe.
// - Replaces the per-block mult16x16 instances so the design needs a single DSP slice.
//
// PARAMETERS
// - NREQ  4  number of requesters (2..8)
// - TAGW  2  requester index width, $clog2(NREQ)
//
// PORTS
// - clk    in   1         system clock
// - rst    in   1         synchronous reset, active-high
// - iReq   in   NREQ      request per requester; held high until granted
// - iA     in   NREQ*17   signed operand A per requester; slot k = iA[17*k +: 17]
// - iB     in   NREQ*16   unsigned coefficient per requester; slot k = iB[16*k +: 16]
// - oGnt   out  NREQ      one-hot grant, combinational from iReq and the pointer
// - oValid out  NREQ      one-hot result strobe, registered
// - oTag   out  TAGW      index of the requester owning oOut
// - oOut   out  16        signed result
//
// BEHAVIOUR
// - Reset:
//   - oValid=0, oTag=0, oOut=0, round-robin pointer=0.
//   - All pipeline valid bits cleared.
//   - Operands already in the pipeline are discarded; no oValid is issued for them.
// - Arbitration (cycle t, rst=0):
//   - Search iReq starting at the pointer, wrapping at NREQ-1 -> 0.
//   - The first set bit k gets oGnt[k]=1. iA/iB slot k are sampled at the t->t+1 edge.
//   - The pointer becomes (k+1) mod NREQ.
//   - If there is no request, oGnt=0 and the pointer is unchanged.
//   - rst=1 forces oGnt=0.
// - Handshake:
//   - A requester treats oGnt[k]=1 in a cycle as acceptance.
//   - It may drop or change iReq/operands in the next cycle.
//   - A requester holding iReq high every cycle is granted again on its next round-robin turn.
// - Pipeline (fixed 2-cycle latency, throughput 1 per cycle):
//   - Stage 1 registers: a (17b signed), b (16b zero-extended to 17b signed), tag, valid.
//   - Stage 2 computes p = a*b (34b signed) and s = p >>> 16 (arithmetic).
//   - Stage 2 output: oOut = sat16(s), where sat16 clamps to [-32768, 32767].
//   - oValid[tag] is asserted at t+2 for exactly one cycle and oTag=tag.
//   - oOut and oTag hold their last values while oValid=0.
// - Back-to-back:
//   - Grants in consecutive cycles give consecutive oValid cycles, with no bubbles.
// - Simultaneous events:
//   - A new grant and a result retiring in the same cycle are independent.
//   - rst in any cycle overrides a grant in that same cycle.
// - Timing limits:
//   - No combinational path from iA/iB to any output.
//   - iReq -> oGnt is the only combinational path.
//
// CONFIGURATION
// - Macro MULT_ARB_PRIO_EN:
//   - Defined: requester 0 has fixed top priority. If iReq[0]=1 it is always granted and the
//     pointer is unchanged. Otherwise round-robin runs over requesters 1..NREQ-1.
//     This guarantees the filter loop its slot each cycle.
//   - Undefined: pure round-robin over all requesters; worst-case wait is NREQ-1 cycles.
//
// TESTING
// - Single request:
//   - Stimulus: iReq=0001, iA[0]=17'h04000, iB[0]=16'h8000 in cycle t.
//   - Expected: oGnt=0001 at t; oValid=0001, oTag=0, oOut=16'h2000 at t+2.
// - Round-robin, all requesting (macro off):
//   - Stimulus: iReq=1111 held for 6 cycles.
//   - Expected: grants 0,1,2,3,0,1; oValid follows 2 cycles later, one per cycle.
// - Saturation:
//   - Stimulus: A=17'h0FFFF, B=16'hFFFF. Expected: oOut=16'h7FFF.
//   - Stimulus: A=17'h10000, B=16'hFFFF. Expected: oOut=16'h8000.
//   - Stimulus: A=17'h1FFFF, B=16'h0001. Expected: oOut=16'hFFFF.
// - Reset mid-flight:
//   - Stimulus: grant requester 2 at t, rst=1 at t+1.
//   - Expected: no oValid at t+2 or t+3, oOut=0, and the next grant after reset goes to requester 0.
// - Priority:
//   - Stimulus: iReq=0101 held for 4 cycles.
//   - Expected with macro defined: grants 0,0,0,0.
//   - Expected with macro undefined: grants 0,2,0,2.
// - Idle and late request:
//   - Stimulus: iReq=0 for 3 cycles, then iReq=1000.
//   - Expected: pointer unchanged while idle; oGnt=1000 immediately, oValid[3] 2 cycles later.

Source files
------------

// File: rtl/mult_arbiter.sv
// rtl/mult_arbiter.sv - round-robin arbiter sharing one pipelined signed 17x16 fractional multiplier
//
// Ports:
//   clk     system clock
//   rst     synchronous reset, active-high
//   iReq    per-requester request, held high until granted
//   iA      per-requester signed 17b operand, slot k = iA[17*k +: 17]
//   iB      per-requester unsigned 16b coefficient, slot k = iB[16*k +: 16]
//   oGnt    one-hot grant, combinational from iReq and the round-robin pointer
//   oValid  one-hot registered result strobe, two cycles after the grant
//   oTag    index of the requester owning oOut
//   oOut    sat16((A*B) >>> 16), holds while oValid=0
// Optional feature macro: MULT_ARB_PRIO_EN (requester 0 gets fixed top priority).
module mult_arbiter #(
  parameter int NREQ = 4,
  parameter int TAGW = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      iReq,
  input  logic [NREQ*17-1:0]   iA,
  input  logic [NREQ*16-1:0]   iB,
  output logic [NREQ-1:0]      oGnt,
  output logic [NREQ-1:0]      oValid,
  output logic [TAGW-1:0]      oTag,
  output logic [15:0]          oOut
);

  localparam logic [TAGW-1:0] LAST = TAGW'(NREQ - 1);

  logic [TAGW-1:0]    ptr_q, ptr_d;
  logic [TAGW-1:0]    cand;
  logic               pick_vld;
  logic [TAGW-1:0]    pick_idx;
  logic               keep_ptr;

  logic               s1_vld_q, s1_vld_d;
  logic signed [16:0] s1_a_q, s1_a_d;
  logic [15:0]        s1_b_q, s1_b_d;
  logic [TAGW-1:0]    s1_tag_q, s1_tag_d;

  logic signed [16:0] s1_bx;
  logic signed [33:0] prod;
  logic signed [33:0] shifted;

  logic [NREQ-1:0]    valid_q, valid_d;
  logic [TAGW-1:0]    tag_q, tag_d;
  logic [15:0]        out_q, out_d;

  // Arbitration: walk the requests starting at the pointer, wrapping at NREQ-1.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    keep_ptr = 1'b0;
    cand     = ptr_q;
`ifdef MULT_ARB_PRIO_EN
    // Requester 0 wins outright and does not advance the pointer.
    if (iReq[0]) begin
      pick_vld = 1'b1;
      keep_ptr = 1'b1;
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!pick_vld && (cand != '0) && iReq[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
      cand = (cand == LAST) ? '0 : cand + 1'b1;
    end
`else
    for (int i = 0; i < NREQ; i++) begin
      if (!pick_vld && iReq[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
      cand = (cand == LAST) ? '0 : cand + 1'b1;
    end
`endif
    ptr_d = ptr_q;
    if (pick_vld && !keep_ptr) begin
      ptr_d = (pick_idx == LAST) ? '0 : pick_idx + 1'b1;
    end
    oGnt = '0;
    if (pick_vld && !rst) begin
      oGnt[pick_idx] = 1'b1;
    end
  end

  // Stage 1 captures the granted slot's operands.
  always_comb begin
    s1_vld_d = pick_vld;
    s1_tag_d = pick_idx;
    s1_a_d   = iA[pick_idx*17 +: 17];
    s1_b_d   = iB[pick_idx*16 +: 16];
  end

  // Stage 2: B is zero-extended so the product treats it as an unsigned fraction.
  always_comb begin
    s1_bx   = $signed({1'b0, s1_b_q});
    prod    = s1_a_q * s1_bx;
    shifted = prod >>> 16;
    valid_d = '0;
    tag_d   = tag_q;
    out_d   = out_q;
    if (s1_vld_q) begin
      valid_d[s1_tag_q] = 1'b1;
      tag_d             = s1_tag_q;
      if (shifted > 34'sd32767) begin
        out_d = 16'h7fff;
      end else if (shifted < -34'sd32768) begin
        out_d = 16'h8000;
      end else begin
        out_d = shifted[15:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q    <= '0;
      s1_vld_q <= 1'b0;
      s1_a_q   <= '0;
      s1_b_q   <= '0;
      s1_tag_q <= '0;
      valid_q  <= '0;
      tag_q    <= '0;
      out_q    <= '0;
    end else begin
      ptr_q    <= ptr_d;
      s1_vld_q <= s1_vld_d;
      s1_a_q   <= s1_a_d;
      s1_b_q   <= s1_b_d;
      s1_tag_q <= s1_tag_d;
      valid_q  <= valid_d;
      tag_q    <= tag_d;
      out_q    <= out_d;
    end
  end

  assign oValid = valid_q;
  assign oTag   = tag_q;
  assign oOut   = out_q;

endmodule
